fence_flush_seq: RTL and testbench

// - Sequences FENCE / FENCE.I completion for the CVA6 write-through dcache subsystem.
// - Drains the store buffer, the write buffer and outstanding stores before anything else.
// - Optionally flushes and invalidates the dcache, then invalidates the icache (FENCE.I only).
// - Sits between commit/controller and the cache subsystem; stalls issue until the fence completes.

---
 rtl/fence_flush_seq_pkg.sv | 17 +
 rtl/fence_seq_timer.sv | 39 +++
 rtl/fence_flush_seq.sv | 113 +++++++++++
 tb/tb_fence_flush_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fence_flush_seq_pkg.sv
// rtl/fence_flush_seq_pkg.sv - shared types and helpers for the fence/flush sequencer
package fence_flush_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        DFLUSH,
        IFLUSH,
        DONE
    } state_e;

    // Counter width able to hold the timeout limit itself (the counter saturates there).
    function automatic int cnt_width(input int timeout_cycles);
        return (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/fence_seq_timer.sv
// rtl/fence_seq_timer.sv - clear/enable saturating wait counter with a one-shot reached pulse
module fence_seq_timer
    import fence_flush_seq_pkg::*;
#(
    parameter int unsigned Limit = 1024,
    parameter int unsigned Width = cnt_width(Limit)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic reached_o
);

    localparam logic [Width-1:0] LimitVal = Width'(Limit);

    logic [Width-1:0] count_q;
    logic             reached_q;

    // Pulse is registered alongside the final increment so it lines up with count_q == Limit;
    // saturation keeps it from firing again until the next clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= '0;
            reached_q <= 1'b0;
        end else begin
            reached_q <= 1'b0;
            if (clear_i) begin
                count_q <= '0;
            end else if (enable_i && (count_q != LimitVal)) begin
                count_q   <= count_q + 1'b1;
                reached_q <= (count_q == (LimitVal - 1'b1));
            end
        end
    end

    assign reached_o = reached_q;

endmodule

// File: rtl/fence_flush_seq.sv
// rtl/fence_flush_seq.sv - FENCE / FENCE.I completion sequencer for the write-through dcache
module fence_flush_seq
    import fence_flush_seq_pkg::*;
#(
    parameter bit          FlushOnFence         = 1'b0,
    parameter bit          InvalidateOnFlush    = 1'b0,
    parameter int unsigned MaxOutstandingStores = 7,
    parameter int unsigned TimeoutCycles        = 1024
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      fence_req_i,
    input  logic                                      fence_i_i,
    input  logic                                      store_buf_empty_i,
    input  logic                                      wbuf_empty_i,
    input  logic [$clog2(MaxOutstandingStores+1)-1:0] outstanding_stores_i,
    output logic                                      dcache_flush_o,
    output logic                                      dcache_inval_o,
    input  logic                                      dcache_flush_ack_i,
    output logic                                      icache_flush_o,
    output logic                                      stall_issue_o,
    output logic                                      fence_ack_o,
    output logic                                      timeout_o
);

    state_e state_q;
    state_e state_d;
    logic   fi_q;
    logic   drain_done;
    logic   state_change;
    logic   wait_state;

    assign drain_done = store_buf_empty_i & wbuf_empty_i & (outstanding_stores_i == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            fi_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && fence_req_i) begin
                fi_q <= fence_i_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fence_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_done) begin
                    if (FlushOnFence) state_d = DFLUSH;
                    else if (fi_q)    state_d = IFLUSH;
                    else              state_d = DONE;
                end
            end
            DFLUSH: begin
                if (dcache_flush_ack_i) state_d = fi_q ? IFLUSH : DONE;
            end
            IFLUSH:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_issue_o  = 1'b0;
        dcache_flush_o = 1'b0;
        icache_flush_o = 1'b0;
        fence_ack_o    = 1'b0;
        unique case (state_q)
            IDLE:    ;
            DRAIN:   stall_issue_o = 1'b1;
            DFLUSH: begin
                stall_issue_o  = 1'b1;
                dcache_flush_o = 1'b1;
            end
            IFLUSH: begin
                stall_issue_o  = 1'b1;
                icache_flush_o = 1'b1;
            end
            DONE: begin
                stall_issue_o = 1'b1;
                fence_ack_o   = 1'b1;
            end
            default: ;
        endcase
    end

    assign dcache_inval_o = dcache_flush_o & InvalidateOnFlush;

    // Wait budget restarts on every transition, so DRAIN and DFLUSH each get a full window.
    assign state_change = (state_d != state_q);
    assign wait_state   = (state_q == DRAIN) || (state_q == DFLUSH);

    fence_seq_timer #(
        .Limit(TimeoutCycles)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_change),
        .enable_i (wait_state),
        .reached_o(timeout_o)
    );

    no_req_while_stalled: assert property (
        @(posedge clk_i) disable iff (rst_i) stall_issue_o |-> !fence_req_i
    );

endmodule

// File: tb/tb_fence_flush_seq.sv
// tb/tb_fence_flush_seq.sv - self-checking bench: per-cycle model compare plus directed latency checks
module tb_fence_flush_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] fence_req;
    logic       fence_i;
    logic       sb_empty;
    logic       wbuf_empty;
    logic [2:0] outstanding;
    logic       flush_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int r_ack, r_flush, r_inval, r_ic, r_stall, r_to, r_to_at, r_start, first_start;

    always #5 clk = ~clk;

    // Instance 0: plain fences, timeout 16. Instance 1: flush+invalidate on fence, timeout 20.
    for (genvar g = 0; g < 2; g++) begin : u
        localparam bit FOF = (g == 1);
        localparam bit INV = (g == 1);
        localparam int TO  = (g == 0) ? 16 : 20;

        logic d_flush, d_inval, i_flush, stall, ack, tmo;
        logic e_stall, e_flush, e_ic, e_ack, e_to, e_inval;
        bit   fi;
        bit   ab;
        int   n;

        fence_flush_seq #(
            .FlushOnFence        (FOF),
            .InvalidateOnFlush   (INV),
            .MaxOutstandingStores(7),
            .TimeoutCycles       (TO)
        ) dut (
            .clk_i               (clk),
            .rst_i               (rst),
            .fence_req_i         (fence_req[g]),
            .fence_i_i           (fence_i),
            .store_buf_empty_i   (sb_empty),
            .wbuf_empty_i        (wbuf_empty),
            .outstanding_stores_i(outstanding),
            .dcache_flush_o      (d_flush),
            .dcache_inval_o      (d_inval),
            .dcache_flush_ack_i  (flush_ack),
            .icache_flush_o      (i_flush),
            .stall_issue_o       (stall),
            .fence_ack_o         (ack),
            .timeout_o           (tmo)
        );

        assign e_inval = e_flush & INV;

        // Fence lifetime as a sequential story; each posedge decides the next cycle's outputs.
        initial begin
            e_stall = 0; e_flush = 0; e_ic = 0; e_ack = 0; e_to = 0;
            forever begin
                e_stall = 0; e_flush = 0; e_ic = 0; e_ack = 0; e_to = 0;
                @(posedge clk);
                if (rst !== 1'b0 || fence_req[g] !== 1'b1) continue;
                fi = fence_i;
                ab = 0;
                e_stall = 1;
                n = 0;
                forever begin
                    @(posedge clk);
                    if (rst) begin ab = 1; break; end
                    if (sb_empty && wbuf_empty && outstanding == 3'd0) break;
                    n++;
                    e_to = (n == TO);
                end
                e_to = 0;
                if (ab) continue;
                if (FOF) begin
                    e_flush = 1;
                    n = 0;
                    forever begin
                        @(posedge clk);
                        if (rst) begin ab = 1; break; end
                        if (flush_ack) break;
                        n++;
                        e_to = (n == TO);
                    end
                    e_flush = 0;
                    e_to = 0;
                    if (ab) continue;
                end
                if (fi) begin
                    e_ic = 1;
                    @(posedge clk);
                    e_ic = 0;
                    if (rst) continue;
                end
                e_ack = 1;
                @(posedge clk);
                e_ack = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("stall0", u[0].stall,   u[0].e_stall);
        chk("dflush0", u[0].d_flush, u[0].e_flush);
        chk("dinval0", u[0].d_inval, u[0].e_inval);
        chk("iflush0", u[0].i_flush, u[0].e_ic);
        chk("ack0",   u[0].ack,     u[0].e_ack);
        chk("tmo0",   u[0].tmo,     u[0].e_to);
        chk("stall1", u[1].stall,   u[1].e_stall);
        chk("dflush1", u[1].d_flush, u[1].e_flush);
        chk("dinval1", u[1].d_inval, u[1].e_inval);
        chk("iflush1", u[1].i_flush, u[1].e_ic);
        chk("ack1",   u[1].ack,     u[1].e_ack);
        chk("tmo1",   u[1].tmo,     u[1].e_to);
    endtask

    task automatic apply(input int test, input int k);
        sb_empty    = 1'b1;
        wbuf_empty  = 1'b1;
        outstanding = 3'd0;
        flush_ack   = 1'b0;
        case (test)
            1: begin
                wbuf_empty  = (k >= 6);
                outstanding = (k < 4) ? 3'd3 : 3'd0;
            end
            2: flush_ack  = (k == 11);
            3: wbuf_empty = (k >= 40);
            default: ;
        endcase
    endtask

    // Issues one fence at offset 0 and tallies the chosen instance's outputs until its ack.
    task automatic run_fence(input int which, input bit fi, input int test, input int max_k);
        logic o_stall, o_flush, o_inval, o_ic, o_ack, o_to;
        r_ack = -1; r_flush = 0; r_inval = 0; r_ic = 0; r_stall = 0; r_to = 0; r_to_at = -1;
        tick();
        r_start = cyc;
        apply(test, 0);
        fence_i = fi;
        fence_req[which] = 1'b1;
        for (int k = 1; k <= max_k; k++) begin
            tick();
            fence_req = '0;
            fence_i   = 1'b0;
            if (which == 0) begin
                o_stall = u[0].stall; o_flush = u[0].d_flush; o_inval = u[0].d_inval;
                o_ic = u[0].i_flush; o_ack = u[0].ack; o_to = u[0].tmo;
            end else begin
                o_stall = u[1].stall; o_flush = u[1].d_flush; o_inval = u[1].d_inval;
                o_ic = u[1].i_flush; o_ack = u[1].ack; o_to = u[1].tmo;
            end
            r_stall += int'(o_stall);
            r_flush += int'(o_flush);
            r_inval += int'(o_inval);
            r_ic    += int'(o_ic);
            if (o_to) begin
                r_to++;
                r_to_at = k;
            end
            if (o_ack) begin
                r_ack = k;
                break;
            end
            apply(test, k);
        end
        if (r_ack < 0) $display("FAIL ack_wait: no ack within %0d cycles", max_k);
        apply(0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acks;
        rst = 1'b1;
        fence_req = '0;
        fence_i = 1'b0;
        apply(0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        tick();
        chk("reset_stall", u[0].stall, 1'b0);
        chk("reset_flush", u[1].d_flush, 1'b0);

        run_fence(0, 1'b0, 0, 10);
        chki("plain_ack_at", r_ack, 2);
        chki("plain_stall_cycles", r_stall, 2);
        chki("plain_flush_cycles", r_flush + r_ic, 0);
        first_start = r_start;
        run_fence(0, 1'b0, 0, 10);
        chki("b2b_second_start", r_start - first_start, 3);
        chki("b2b_second_ack_at", r_ack, 2);

        run_fence(0, 1'b1, 0, 10);
        chki("fencei_ack_at", r_ack, 3);
        chki("fencei_icache_pulses", r_ic, 1);

        run_fence(0, 1'b0, 1, 20);
        chki("blocked_ack_at", r_ack, 7);
        chki("blocked_stall_cycles", r_stall, 7);

        run_fence(1, 1'b1, 2, 30);
        chki("flush_ack_at", r_ack, 13);
        chki("flush_cycles", r_flush, 10);
        chki("inval_cycles", r_inval, 10);
        chki("flush_icache_pulses", r_ic, 1);

        run_fence(1, 1'b0, 2, 30);
        chki("flush_plain_ack_at", r_ack, 12);

        run_fence(0, 1'b0, 3, 60);
        chki("timeout_pulses", r_to, 1);
        chki("timeout_at", r_to_at, 17);
        chki("timeout_ack_at", r_ack, 41);

        tick();
        apply(0, 0);
        fence_req[1] = 1'b1;
        tick();
        fence_req = '0;
        tick();
        tick();
        chk("rst_pre_flush", u[1].d_flush, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_flush_drop", u[1].d_flush, 1'b0);
        chk("rst_inval_drop", u[1].d_inval, 1'b0);
        chk("rst_stall_drop", u[1].stall, 1'b0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            acks += int'(u[1].ack);
        end
        chki("rst_no_ack", acks, 0);
        run_fence(1, 1'b1, 2, 30);
        chki("rst_then_ack_at", r_ack, 13);

        for (int i = 0; i < 3000; i++) begin
            tick();
            rst         = ($urandom_range(0, 299) == 0);
            sb_empty    = ($urandom_range(0, 3) != 0);
            wbuf_empty  = ($urandom_range(0, 3) != 0);
            outstanding = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            flush_ack   = ($urandom_range(0, 3) == 0);
            fence_i     = ($urandom_range(0, 1) == 1);
            fence_req[0] = !u[0].e_stall && ($urandom_range(0, 2) == 0);
            fence_req[1] = !u[1].e_stall && ($urandom_range(0, 2) == 0);
        end
        rst = 1'b0;
        fence_req = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
